// File: rtl/hmc835_pkg.sv
// Shared definitions for the HMC835 register-programming sequencer:
// state encodings, HMC835 SPI word field positions and default poll settings.
package hmc835_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_ARM   = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;
  localparam logic [2:0] ST_CHECK = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;

  // HMC835 SPI word layout: rw bit, 6-bit register address, 24-bit data
  localparam int unsigned HMC_RW_BIT   = 31;
  localparam int unsigned HMC_ADDR_MSB = 30;
  localparam int unsigned HMC_ADDR_LSB = 25;
  localparam int unsigned HMC_DATA_MSB = 24;
  localparam int unsigned HMC_DATA_LSB = 1;

  // Read of register 0x12 (lock detect); lock flag is bit 2 of the read data
  localparam logic [31:0] HMC_POLL_WORD = 32'hA4000000;
  localparam int unsigned HMC_LOCK_BIT  = 2;

endpackage

// File: rtl/hmc835_seq_table.sv
// 2^ADDR_W x 32 word table: one synchronous write port, one synchronous read port.
module hmc835_seq_table #(
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [31:0]       rd_data
);

  logic [31:0] mem [2**ADDR_W];

  // A read and write to the same address in one cycle returns the old word
  always_ff @(posedge clock) begin
    if (we)
      mem[wr_addr] <= wr_data;
    if (rd_en)
      rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/hmc835_seq.sv
// Replays a host-loaded table of SPI words to the HMC835 SPI master with a
// minimum CS-high gap, then optionally polls lock detect until lock or timeout.
module hmc835_seq
  import hmc835_pkg::*;
#(
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned GAP_CYCLES = 4,
  parameter logic [31:0] POLL_WORD  = HMC_POLL_WORD,
  parameter int unsigned LOCK_BIT   = HMC_LOCK_BIT,
  parameter int unsigned POLL_MAX   = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              tbl_we,
  input  logic [ADDR_W-1:0] tbl_addr,
  input  logic [31:0]       tbl_data,
  input  logic              start,
  input  logic [ADDR_W:0]   count,
  input  logic              poll_en,
  output logic              busy,
  output logic              done,
  output logic              locked,
  output logic              timeout,
  output logic [31:0]       rdata_last,
  output logic              spi_write,
  output logic [31:0]       spi_din,
  input  logic              spi_busy,
  input  logic [31:0]       spi_rdata
);

  logic [2:0]        state;
  logic [ADDR_W:0]   idx;
  logic [ADDR_W:0]   idx_inc;
  logic [ADDR_W:0]   cnt_q;
  logic              poll_en_q;
  logic              poll_phase;
  logic [7:0]        gap_cnt;
  logic [7:0]        polls;
  logic [31:0]       din_q;
  logic [31:0]       rd_data;
  logic [31:0]       word_sel;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic              issue;

  assign idx_inc = idx + 1'b1;

  // Reads happen only in IDLE/GAP so the word stays stable while ISSUE waits
  always_comb begin
    rd_en    = (state == ST_IDLE) || (state == ST_GAP);
    rd_addr  = (state == ST_GAP) ? idx_inc[ADDR_W-1:0] : '0;
    issue    = (state == ST_ISSUE) && !spi_busy;
    word_sel = poll_phase ? POLL_WORD : rd_data;
  end

  assign spi_write = issue;
  assign spi_din   = (state == ST_ISSUE) ? word_sel : din_q;

  hmc835_seq_table #(.ADDR_W(ADDR_W)) u_table (
    .clock   (clock),
    .we      (tbl_we && !busy),
    .wr_addr (tbl_addr),
    .wr_data (tbl_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      idx        <= '0;
      cnt_q      <= '0;
      poll_en_q  <= 1'b0;
      poll_phase <= 1'b0;
      gap_cnt    <= '0;
      polls      <= '0;
      din_q      <= '0;
      rdata_last <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      locked     <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (issue)
        din_q <= word_sel;
      case (state)
        ST_IDLE: begin
          if (start) begin
            cnt_q      <= count;
            poll_en_q  <= poll_en;
            locked     <= 1'b0;
            timeout    <= 1'b0;
            idx        <= '0;
            polls      <= '0;
            poll_phase <= 1'b0;
            busy       <= 1'b1;
            if (count == '0) begin
              if (poll_en) begin
                poll_phase <= 1'b1;
                polls      <= 8'd1;
                state      <= ST_ISSUE;
              end else begin
                state <= ST_DONE;
              end
            end else begin
              state <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: if (!spi_busy) state <= ST_ARM;
        ST_ARM:   state <= ST_WAIT;
        ST_WAIT: begin
          if (!spi_busy) begin
            rdata_last <= spi_rdata;
            gap_cnt    <= 8'(GAP_CYCLES - 1);
            state      <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 8'd1;
          end else if (poll_phase) begin
            state <= ST_CHECK;
          end else begin
            idx <= idx_inc;
            if (idx_inc < cnt_q) begin
              state <= ST_ISSUE;
            end else if (poll_en_q) begin
              poll_phase <= 1'b1;
              polls      <= 8'd1;
              state      <= ST_ISSUE;
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_CHECK: begin
          if (rdata_last[LOCK_BIT]) begin
            locked <= 1'b1;
            state  <= ST_DONE;
          end else if (polls == 8'(POLL_MAX)) begin
            timeout <= 1'b1;
            state   <= ST_DONE;
          end else begin
            polls <= polls + 8'd1;
            state <= ST_ISSUE;
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hmc835_seq.sv
// Self-checking bench for hmc835_seq: SPI master model plus a sequence-level
// reference that predicts words, gaps, lock/timeout and done for each run.
module tb_hmc835_seq;

  localparam int          AW    = 5;
  localparam int          GAP   = 4;
  localparam int          LB    = 2;
  localparam int          PMAX  = 4;
  localparam logic [31:0] POLLW = 32'hA4000000;

  logic          clock = 1'b0;
  logic          reset;
  logic          tbl_we;
  logic [AW-1:0] tbl_addr;
  logic [31:0]   tbl_data;
  logic          start;
  logic [AW:0]   count;
  logic          poll_en;
  logic          busy, done, locked, timeout;
  logic [31:0]   rdata_last;
  logic          spi_write;
  logic [31:0]   spi_din;
  logic          spi_busy = 1'b0;
  logic [31:0]   spi_rdata = '0;

  hmc835_seq #(
    .ADDR_W(AW), .GAP_CYCLES(GAP), .POLL_WORD(POLLW), .LOCK_BIT(LB), .POLL_MAX(PMAX)
  ) dut (
    .clock(clock), .reset(reset), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
    .tbl_data(tbl_data), .start(start), .count(count), .poll_en(poll_en),
    .busy(busy), .done(done), .locked(locked), .timeout(timeout),
    .rdata_last(rdata_last), .spi_write(spi_write), .spi_din(spi_din),
    .spi_busy(spi_busy), .spi_rdata(spi_rdata)
  );

  always #5 clock = ~clock;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          busy_len = 4;
  int          rem = 0;
  logic [31:0] resp_q[$];
  logic [31:0] wr_q[$];
  int          wr_cyc[$];
  int          fall_cyc[$];
  int          done_cnt, done_cyc, overlap;
  logic        done_busy;
  logic        prev_busy = 1'b0;
  logic [31:0] ref_tbl [32];
  logic [31:0] exp_rdata = '0;

  always @(posedge clock) cyc <= cyc + 1;

  // SPI master model: busy rises the cycle after a write, lasts busy_len cycles
  always @(posedge clock) begin
    if (spi_write) begin
      spi_busy  <= 1'b1;
      rem       <= busy_len - 1;
      spi_rdata <= (resp_q.size() > 0) ? resp_q.pop_front() : 32'h0;
    end else if (spi_busy) begin
      if (rem == 0) spi_busy <= 1'b0;
      else rem <= rem - 1;
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      if (prev_busy && !spi_busy && wr_q.size() > 0) fall_cyc.push_back(cyc);
      if (spi_write) begin
        wr_q.push_back(spi_din);
        wr_cyc.push_back(cyc);
        if (spi_busy) overlap++;
      end
      if (done) begin
        done_cnt++;
        done_cyc  = cyc;
        done_busy = busy;
      end
    end
    prev_busy = spi_busy;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_locked"}, 32'(locked), 0);
    chk({tag, "_timeout"}, 32'(timeout), 0);
    chk({tag, "_rdata"}, rdata_last, 0);
    chk({tag, "_write"}, 32'(spi_write), 0);
    chk({tag, "_din"}, spi_din, 0);
  endtask

  task automatic run(input int cnt, input bit pen, input int lock_at, input int blen,
                     input bit inject);
    int          exp_polls, t0, n;
    bit          exp_lock, idle_at_start;
    logic [31:0] exp_w[$];
    logic [31:0] r;
    exp_lock  = pen && lock_at >= 1 && lock_at <= PMAX;
    exp_polls = !pen ? 0 : (exp_lock ? lock_at : PMAX);
    for (int i = 0; i < cnt; i++) exp_w.push_back(ref_tbl[i]);
    repeat (exp_polls) exp_w.push_back(POLLW);
    resp_q.delete();
    for (int i = 0; i < cnt; i++) resp_q.push_back($urandom);
    for (int j = 1; j <= exp_polls; j++) begin
      r = $urandom;
      r[LB] = (j == lock_at);
      resp_q.push_back(r);
    end
    if (resp_q.size() > 0) exp_rdata = resp_q[$];
    busy_len = blen;
    wr_q.delete(); wr_cyc.delete(); fall_cyc.delete();
    done_cnt = 0; overlap = 0; done_cyc = 0; done_busy = 1'b1;
    idle_at_start = !spi_busy;
    start = 1'b1; count = (AW+1)'(cnt); poll_en = pen; t0 = cyc;
    tick();
    start = 1'b0; count = (AW+1)'($urandom); poll_en = ~pen;
    @(negedge clock);
    chk("busy_after_start", 32'(busy), 1);
    tick();
    n = 0;
    while (done_cnt == 0 && n < 20000) begin
      if (inject && n == 30) begin
        start = 1'b1; tbl_we = 1'b1; tbl_addr = 1; tbl_data = ~ref_tbl[1];
      end else if (inject && n == 31) begin
        start = 1'b0; tbl_we = 1'b0;
      end
      tick();
      n++;
    end
    start = 1'b0; tbl_we = 1'b0;
    chk("done_seen", 32'(done_cnt > 0), 1);
    repeat (4) tick();
    chk("done_once", done_cnt, 1);
    chk("busy_low_at_done", 32'(done_busy), 0);
    if (cnt == 0 && !pen) chk("done_latency", done_cyc - t0, 2);
    chk("write_count", wr_q.size(), exp_w.size());
    for (int i = 0; i < exp_w.size() && i < wr_q.size(); i++)
      chk($sformatf("word%0d", i), wr_q[i], exp_w[i]);
    if (idle_at_start && wr_cyc.size() > 0) chk("first_write_latency", wr_cyc[0] - t0, 1);
    for (int i = 0; i + 1 < wr_cyc.size() && i < fall_cyc.size(); i++)
      chk($sformatf("gap%0d", i), wr_cyc[i+1] - fall_cyc[i], (i < cnt) ? GAP + 1 : GAP + 2);
    chk("locked", 32'(locked), 32'(exp_lock));
    chk("timeout", 32'(timeout), 32'(pen && !exp_lock));
    chk("rdata_last", rdata_last, exp_rdata);
    chk("busy_end", 32'(busy), 0);
    chk("no_overlap", overlap, 0);
  endtask

  initial begin
    int n;
    reset = 1'b1; tbl_we = 1'b0; tbl_addr = '0; tbl_data = '0;
    start = 1'b0; count = '0; poll_en = 1'b0;
    repeat (3) tick();
    @(negedge clock);
    chk_quiet("reset");
    tick();
    reset = 1'b0;

    for (int i = 0; i < 32; i++) ref_tbl[i] = $urandom;
    ref_tbl[0] = 32'h20000002; ref_tbl[1] = 32'h02000400; ref_tbl[2] = 32'h0C123456;
    for (int i = 0; i < 32; i++) begin
      tbl_we = 1'b1; tbl_addr = AW'(i); tbl_data = ref_tbl[i];
      tick();
    end
    tbl_we = 1'b0;

    run(3, 1'b0, 0, 69, 1'b0);
    run(0, 1'b0, 0, 5, 1'b0);
    run(2, 1'b1, 3, $urandom_range(3, 10), 1'b0);
    run(0, 1'b1, 0, $urandom_range(3, 10), 1'b0);
    for (int k = 0; k < 4; k++)
      run($urandom_range(1, 32), 1'($urandom_range(0, 1)), $urandom_range(0, 6),
          $urandom_range(2, 12), 1'b0);
    run(32, 1'b1, 2, 3, 1'b0);
    run(5, 1'b0, 0, 6, 1'b1);
    run(5, 1'b0, 0, 6, 1'b0);

    // Reset while the SPI model is mid-frame, then restart at once
    busy_len = 40;
    resp_q.delete(); resp_q.push_back($urandom);
    wr_q.delete();
    start = 1'b1; count = 3; poll_en = 1'b0;
    tick();
    start = 1'b0;
    n = 0;
    while (wr_q.size() == 0 && n < 100) begin tick(); n++; end
    chk("reset_test_first_write", 32'(wr_q.size() > 0), 1);
    repeat (10) tick();
    reset = 1'b1;
    tick();
    @(negedge clock);
    chk_quiet("mid_reset");
    chk("model_still_busy", 32'(spi_busy), 1);
    tick();
    reset = 1'b0;
    exp_rdata = '0;
    run(1, 1'b0, 0, 8, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hmc835_seq.md
# hmc835_seq

Register-programming sequencer that sits directly upstream of the HMC835 SPI master. It holds a host-loaded table of 32-bit SPI words and replays them to the master one at a time, honouring its busy handshake and enforcing a minimum CS-high gap. It can optionally poll the PLL lock-detect register afterwards, reporting lock or timeout. The host loads the table and pulses start; the SPI master then sees only clean, non-overlapping write pulses.

## Interface
- ADDR_W, 5: table address width, giving 2^ADDR_W entries.
- GAP_CYCLES, 4: idle cycles after spi_busy falls before the next spi_write (min CS-high time); range 1..255.
- POLL_WORD, 32'hA4000000: word sent for each lock poll (read, reg 0x12).
- LOCK_BIT, 2: bit of spi_rdata that indicates lock.
- POLL_MAX, 255: maximum number of poll transactions before timeout; range 1..255.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- tbl_we  in  1  table write strobe; accepted only while busy=0.
- tbl_addr  in  ADDR_W  table write address.
- tbl_data  in  32  SPI word to store, sent verbatim.
- start  in  1  single-cycle start pulse; accepted only in IDLE.
- count  in  ADDR_W+1  number of table words to send (0..2^ADDR_W), sampled on start.
- poll_en  in  1  run lock polling after the table; sampled on start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at sequence end.
- locked  out  1  sticky lock result; cleared on start.
- timeout  out  1  sticky poll timeout; cleared on start.
- rdata_last  out  32  spi_rdata captured at the end of the most recent transaction.
- spi_write  out  1  one-cycle pulse to the SPI master.
- spi_din  out  32  word presented with spi_write, held until the next issue.
- spi_busy  in  1  SPI master busy. It rises one cycle after spi_write.
- spi_rdata  in  32  SPI master read shift data; valid while spi_busy=0.

## Operation
- Reset: all outputs 0, state IDLE, counters 0. Table contents are not cleared.
- If reset occurs mid-transaction, the SPI master (which has no reset) finishes its frame. The sequencer's ISSUE state waits out spi_busy before any new write.
- States:
  - IDLE: on start, latch count and poll_en, clear locked/timeout, set idx=0.
    - If count=0 and poll_en=1, go to POLL_ISSUE.
    - If count=0 and poll_en=0, go to DONE.
    - Otherwise go to ISSUE.
  - ISSUE: hold while spi_busy=1. Otherwise pulse spi_write with spi_din=table[idx] (or POLL_WORD in poll phase), then go to ARM.
  - ARM: exactly one cycle. Covers the registered rise of spi_busy and ignores spi_busy in this cycle. Go to WAIT.
  - WAIT: hold while spi_busy=1. On the first spi_busy=0 cycle, capture rdata_last<=spi_rdata, load gap counter, and go to GAP.
  - GAP: count GAP_CYCLES cycles, then:
    - in table phase: idx+1; if idx+1<count go to ISSUE, else go to POLL_ISSUE (if poll_en) or DONE;
    - in poll phase: go to POLL_CHECK.
  - POLL_CHECK (one cycle, tests rdata_last, not live spi_rdata):
    - rdata_last[LOCK_BIT]=1: set locked, go to DONE;
    - else if polls==POLL_MAX: set timeout, go to DONE;
    - else polls+1, go to ISSUE.
  - DONE: pulse done, drop busy, go to IDLE.
- Ignored inputs:
  - start is ignored when not in IDLE;
  - tbl_we is ignored while busy=1 (the table is stable during replay);
  - start and tbl_we in the same IDLE cycle: the write lands and start reads the pre-write contents of that address.
- Counters:
  - idx is ADDR_W+1 bits, so count=2^ADDR_W is legal with no wrap.
  - polls is 8 bits and saturates at POLL_MAX.

## Timing
- Accepted start at cycle t: busy=1 at t+1. The first spi_write is at t+1 (ISSUE), or later if spi_busy is still high.
- Let b be the first cycle WAIT sees spi_busy=0. rdata_last updates at b+1, and the next spi_write is at b+GAP_CYCLES+1.
- The table read is synchronous (1 cycle). The read for idx is issued in GAP/IDLE so data is ready in ISSUE.
- done and busy=0 appear in the same cycle. locked/timeout are valid on and after done.

## Structure
- Package hmc835_pkg holds the state encoding localparams, the HMC word field positions (rw bit 31, addr 30:25, data 24:1), and the default POLL_WORD/LOCK_BIT.
- Sub-module hmc835_seq_table is a 2^ADDR_W x 32 single-port-write / single-port-read synchronous RAM.

## Test plan
- Load 3 words (0x20000002, 0x02000400, 0x0C123456), count=3, poll_en=0, SPI model busy 69 cycles → exactly 3 spi_write pulses carrying those words in order, at least GAP_CYCLES+1 cycles between busy-fall and next write, single done, locked=0.
- count=0, poll_en=0 → done 2 cycles after start, no spi_write.
- poll_en=1, model returns bit2=1 on third poll → 3 POLL_WORD writes, locked=1, timeout=0.
- poll_en=1, POLL_MAX=4, bit never set → 4 polls, timeout=1, locked=0, done once.
- Assert reset mid-WAIT while the model is busy, then start immediately → no spi_write until spi_busy=0; all outputs 0 during reset.
- start and tbl_we pulsed during a run → ignored; table unchanged, sequence completes normally.
